// File: rtl/alu_control_stage.sv
// Registered RV32I ALU-control decoder at the ID/EX boundary.
// It produces an ALU op code, an immediate select, an illegal flag and a saturating illegal count.
module alu_control_stage #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               valid_in,
    input  logic               stall,
    input  logic               flush,
    output logic [2:0]         alu_control,
    output logic               alu_src_imm,
    output logic               valid_out,
    output logic               illegal,
    output logic [COUNT_W-1:0] illegal_count
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [2:0] op;
        logic       imm;
        logic       ill;
    } dec_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t       dec;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Every legal path clears ill. An illegal decode is then forced to add and register operand B.
    always_comb begin
        dec     = '0;
        dec.ill = 1'b1;
        case (opc)
            7'b0110011: begin
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ZERO)     begin dec.op = OP_ADD; dec.ill = 1'b0; end
                        else if (f7 == F7_ALT) begin dec.op = OP_SUB; dec.ill = 1'b0; end
                    end
                    3'b001: if (f7 == F7_ZERO) begin dec.op = OP_SLL; dec.ill = 1'b0; end
                    3'b010: if (f7 == F7_ZERO) begin dec.op = OP_SLT; dec.ill = 1'b0; end
                    3'b101: begin
                        if (f7 == F7_ZERO)     begin dec.op = OP_SRL; dec.ill = 1'b0; end
                        else if (f7 == F7_ALT) begin dec.op = OP_SRA; dec.ill = 1'b0; end
                    end
                    3'b110: if (f7 == F7_ZERO) begin dec.op = OP_OR;  dec.ill = 1'b0; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                dec.imm = 1'b1;
                case (f3)
                    3'b000: begin dec.op = OP_ADD; dec.ill = 1'b0; end
                    3'b010: begin dec.op = OP_SLT; dec.ill = 1'b0; end
                    3'b110: begin dec.op = OP_OR;  dec.ill = 1'b0; end
                    3'b001: if (f7 == F7_ZERO) begin dec.op = OP_SLL; dec.ill = 1'b0; end
                    3'b101: begin
                        if (f7 == F7_ZERO)     begin dec.op = OP_SRL; dec.ill = 1'b0; end
                        else if (f7 == F7_ALT) begin dec.op = OP_SRA; dec.ill = 1'b0; end
                    end
                    default: ;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b1101111: begin
                dec.op  = OP_ADD;
                dec.imm = 1'b1;
                dec.ill = 1'b0;
            end
            7'b1100011: begin
                case (f3)
                    3'b000, 3'b001: begin dec.op = OP_SUB; dec.ill = 1'b0; end
                    3'b100, 3'b101: begin dec.op = OP_SLT; dec.ill = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (dec.ill) begin
            dec.op  = OP_ADD;
            dec.imm = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_control   <= '0;
            alu_src_imm   <= 1'b0;
            valid_out     <= 1'b0;
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            alu_control <= '0;
            alu_src_imm <= 1'b0;
            valid_out   <= 1'b0;
            illegal     <= 1'b0;
        end else if (!stall) begin
            valid_out <= valid_in;
            if (valid_in) begin
                alu_control <= dec.op;
                alu_src_imm <= dec.imm;
                illegal     <= dec.ill;
                if (dec.ill && (illegal_count != {COUNT_W{1'b1}}))
                    illegal_count <= illegal_count + 1'b1;
            end else begin
                alu_control <= '0;
                alu_src_imm <= 1'b0;
                illegal     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_stage.sv
// Directed bench for alu_control_stage: one task per scenario, each with hand-computed expectations.
// A second instance with COUNT_W = 2 exercises counter saturation.
module tb_alu_control_stage;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [2:0]  alu_control;
    logic        alu_src_imm;
    logic        valid_out;
    logic        illegal;
    logic [15:0] illegal_count;
    logic [2:0]  s_alu_control;
    logic        s_alu_src_imm;
    logic        s_valid_out;
    logic        s_illegal;
    logic [1:0]  s_illegal_count;

    int vectors;
    int miscompares;

    alu_control_stage #(.COUNT_W(16)) dut (
        .clock(clock), .reset(reset), .instr(instr), .valid_in(valid_in),
        .stall(stall), .flush(flush), .alu_control(alu_control),
        .alu_src_imm(alu_src_imm), .valid_out(valid_out), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    alu_control_stage #(.COUNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .instr(instr), .valid_in(valid_in),
        .stall(stall), .flush(flush), .alu_control(s_alu_control),
        .alu_src_imm(s_alu_src_imm), .valid_out(s_valid_out), .illegal(s_illegal),
        .illegal_count(s_illegal_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    // Drive one cycle of inputs, then step past the rising edge so outputs are settled.
    task automatic step(input logic [31:0] i, input logic v, input logic s, input logic f, input logic r);
        instr    = i;
        valid_in = v;
        stall    = s;
        flush    = f;
        reset    = r;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        step(I_SUB, 1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({alu_control, alu_src_imm, valid_out, illegal} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got op=%b imm=%b v=%b ill=%b exp all 0",
                     alu_control, alu_src_imm, valid_out, illegal);
        end
        vectors++;
        if (illegal_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d exp 0", illegal_count);
        end
        step(I_SUB, 1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({alu_control, valid_out, illegal_count} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_hold got op=%b v=%b cnt=%0d exp 0", alu_control, valid_out, illegal_count);
        end
    endtask

    task automatic test_rtype;
        logic [31:0] ins [5] = '{I_SUB, I_SRA, I_OR, I_SLT, 32'h002091B3};
        logic [2:0]  exp [5] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b001};
        for (int k = 0; k < 5; k++) begin
            instr = ins[k]; valid_in = 1'b1; stall = 1'b0; flush = 1'b0; reset = 1'b0;
            #1;
            if (k > 0) begin
                // New instruction presented but no edge yet: previous result must still be held.
                vectors++;
                if (alu_control !== exp[k-1]) begin
                    miscompares++;
                    $display("FAIL rtype_latency[%0d] got %b exp %b", k, alu_control, exp[k-1]);
                end
            end
            @(posedge clock);
            #1;
            vectors++;
            if ({alu_control, alu_src_imm, valid_out, illegal} !== {exp[k], 3'b010}) begin
                miscompares++;
                $display("FAIL rtype[%0d] got op=%b imm=%b v=%b ill=%b exp op=%b imm=0 v=1 ill=0",
                         k, alu_control, alu_src_imm, valid_out, illegal, exp[k]);
            end
        end
    endtask

    task automatic test_imm_branch;
        logic [31:0] ins [7] = '{32'h00508093, 32'h4010D093, 32'h0000A083, 32'h00208463,
                                 32'h0020C463, 32'h00001037, 32'h0020A463};
        logic [2:0]  exp [7] = '{3'b000, 3'b010, 3'b000, 3'b011, 3'b100, 3'b000, 3'b000};
        logic        imm [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            step(ins[k], 1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if ({alu_control, alu_src_imm, valid_out, illegal} !== {exp[k], imm[k], 1'b1, ill[k]}) begin
                miscompares++;
                $display("FAIL imm_branch[%0d] got op=%b imm=%b v=%b ill=%b exp op=%b imm=%b v=1 ill=%b",
                         k, alu_control, alu_src_imm, valid_out, illegal, exp[k], imm[k], ill[k]);
            end
        end
    endtask

    task automatic test_stall_flush;
        step(I_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(I_OR, 1'b1, 1'b1, 1'b0, 1'b0);
            vectors++;
            if ({alu_control, valid_out} !== 4'b0111) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got op=%b v=%b exp op=011 v=1", k, alu_control, valid_out);
            end
        end
        step(I_OR, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({alu_control, alu_src_imm, valid_out, illegal} !== 6'b0) begin
            miscompares++;
            $display("FAIL stall_flush got op=%b imm=%b v=%b ill=%b exp all 0",
                     alu_control, alu_src_imm, valid_out, illegal);
        end
        step(I_OR, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({alu_control, valid_out} !== 4'b1101) begin
            miscompares++;
            $display("FAIL stall_release got op=%b v=%b exp op=110 v=1", alu_control, valid_out);
        end
        step(I_SRA, 1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({alu_control, valid_out} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_stall got op=%b v=%b exp 0", alu_control, valid_out);
        end
    endtask

    task automatic test_illegal;
        step(I_BAD, 1'b1, 1'b0, 1'b0, 1'b1);
        step(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({alu_control, alu_src_imm, valid_out, illegal} !== 6'b000011 || illegal_count !== 16'd1) begin
            miscompares++;
            $display("FAIL illegal_load got op=%b imm=%b v=%b ill=%b cnt=%0d exp op=000 imm=0 v=1 ill=1 cnt=1",
                     alu_control, alu_src_imm, valid_out, illegal, illegal_count);
        end
        step(I_BAD, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({valid_out, illegal} !== 2'b00 || illegal_count !== 16'd1) begin
            miscompares++;
            $display("FAIL illegal_bubble got v=%b ill=%b cnt=%0d exp v=0 ill=0 cnt=1",
                     valid_out, illegal, illegal_count);
        end
        step(I_BAD, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({valid_out, illegal} !== 2'b00 || illegal_count !== 16'd1) begin
            miscompares++;
            $display("FAIL illegal_flush got v=%b ill=%b cnt=%0d exp v=0 ill=0 cnt=1",
                     valid_out, illegal, illegal_count);
        end
        step(I_SLTU, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({alu_control, illegal} !== 4'b0001 || illegal_count !== 16'd2) begin
            miscompares++;
            $display("FAIL illegal_rtype got op=%b ill=%b cnt=%0d exp op=000 ill=1 cnt=2",
                     alu_control, illegal, illegal_count);
        end
        step(I_BAD, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (illegal_count !== 16'd2) begin
            miscompares++;
            $display("FAIL illegal_stall got cnt=%0d exp 2", illegal_count);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(I_BAD, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (s_illegal_count !== exp[k] || s_illegal !== 1'b1) begin
                miscompares++;
                $display("FAIL saturate[%0d] got cnt=%0d ill=%b exp cnt=%0d ill=1",
                         k, s_illegal_count, s_illegal, exp[k]);
            end
        end
        vectors++;
        if (illegal_count !== 16'd5) begin
            miscompares++;
            $display("FAIL wide_count got %0d exp 5", illegal_count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        instr = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; reset = 1'b1;
        #2;
        test_reset;
        test_rtype;
        test_imm_branch;
        test_stall_flush;
        test_illegal;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_control_stage.md
# alu_control_stage

Registered ALU-control decoder sitting at the ID/EX pipeline boundary, upstream of the ALU. Decodes a 32-bit RV32I instruction into the 3-bit ALU operation code the ALU consumes, plus an immediate-operand select. Results are registered and obey the pipeline's stall/flush hazard controls. Unsupported instructions are flagged and counted in a saturating counter.

## Interface
- `COUNT_W`, 16, width of the saturating illegal-instruction counter
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `instr`  in  32  instruction from the IF/ID register
- `valid_in`  in  1  `instr` carries a real instruction (0 = bubble)
- `stall`  in  1  hold all registered outputs (from the hazard unit)
- `flush`  in  1  replace the stage contents with a bubble (branch mispredict)
- `alu_control`  out  3  registered ALU op code
- `alu_src_imm`  out  1  registered; 1 = operand B is the immediate
- `valid_out`  out  1  registered; stage holds a real instruction
- `illegal`  out  1  registered; held instruction is not decodable
- `illegal_count`  out  COUNT_W  saturating count of illegal instructions accepted

## Operation
- ALU op codes: 000 add, 001 sll, 010 sra, 011 sub, 100 slt, 101 srl, 110 or. Code 111 is never emitted.
- Fields: opc = `instr[6:0]`, f3 = `instr[14:12]`, f7 = `instr[31:25]`.
- R-type (opc 0110011, alu_src_imm = 0):
  - f3 000: f7 0000000 → 000; f7 0100000 → 011.
  - f3 001: f7 0000000 → 001.
  - f3 010: f7 0000000 → 100.
  - f3 101: f7 0000000 → 101; f7 0100000 → 010.
  - f3 110: f7 0000000 → 110.
  - Any other f3/f7 combination is illegal.
- I-ALU (opc 0010011, alu_src_imm = 1):
  - f3 000 → 000; f3 010 → 100; f3 110 → 110.
  - f3 001 requires f7 = 0000000 → 001.
  - f3 101: f7 0000000 → 101; f7 0100000 → 010.
  - Any other encoding is illegal.
- Load (0000011), store (0100011), jalr (1100111): 000, imm = 1.
- lui (0110111), auipc (0010111), jal (1101111): 000, imm = 1.
- Branch (1100011), imm = 0:
  - f3 000/001 → 011.
  - f3 100/101 → 100.
  - Other f3 values are illegal.
- All other opcodes are illegal.
- Illegal decode: alu_control = 000, alu_src_imm = 0, illegal = 1.
- A bubble (`valid_in` = 0) loads valid_out = 0, illegal = 0, alu_control = 000, alu_src_imm = 0, regardless of `instr`.
- Update priority each edge: reset > flush > stall > load.
  - reset: all outputs 0, illegal_count = 0.
  - flush: valid_out = 0, illegal = 0, alu_control = 000, alu_src_imm = 0. illegal_count unchanged.
  - stall (no flush): every register holds, counter included.
  - load: decode `instr` and register the result.
- illegal_count increments by 1 only on a load edge with `valid_in` = 1 and an illegal decode.
  - Saturates at 2^COUNT_W−1; never wraps.
  - Not incremented on stall or flush edges, even if the incoming instruction is illegal.

## Timing
- Latency: 1 cycle. Decode of `instr` at edge N is visible on the outputs after edge N.
- All outputs come directly from flops; no combinational input→output path.
- Reset values: alu_control 000, alu_src_imm 0, valid_out 0, illegal 0, illegal_count 0.
- Reset takes effect only on a clock edge. Asserting reset mid-stall clears state on that edge; the stall is ignored.
- flush and stall together: flush wins and the bubble is inserted.
- Stall held for k cycles: outputs stay constant for k cycles, then the instruction present at the first non-stall edge loads.

## Test plan
- Reset: assert reset 2 cycles with stall = 1 → all outputs 0 and illegal_count = 0 after the first edge.
- R-type sweep, one per cycle: `sub x3,x1,x2` (0x402081B3) → 011, imm 0; `sra` (0x4020D1B3) → 010; `or` (0x0020E1B3) → 110; `slt` (0x0020A1B3) → 100. Each appears exactly 1 cycle after presentation.
- I/load/branch: `addi` 0x00508093 → 000, imm 1; `srai` 0x4010D093 → 010, imm 1; `lw` 0x0000A083 → 000, imm 1; `beq` 0x00208463 → 011, imm 0; `blt` 0x0020C463 → 100, imm 0.
- Stall/flush: load `sub`, hold stall 3 cycles while `instr` = `or` → alu_control stays 011; then stall = flush = 1 → valid_out 0, alu_control 000 next cycle.
- Illegal: present opcode 1111111 with valid_in = 1 → illegal 1, alu_control 000, count 1. Same with valid_in = 0 → count unchanged. Same with flush = 1 → count unchanged.
- Saturation: set COUNT_W = 2 and feed 5 consecutive illegal instructions → count sequence 1, 2, 3, 3, 3.
